seg7_scan_reader: RTL and testbench
===================================

SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

Interface
REQ-001 Parameter SETTLE, default 4: consecutive cycles a digit select must be stable and one-hot before its segments are sampled (range 1-255).
REQ-002 Parameter TIMEOUT, default 4096: maximum cycles allowed in CAPTURE before the frame is abandoned (range 16-65535).
REQ-003 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-004 RESET  in  1  synchronous reset, active-high.
REQ-005 seg_in  in  7  active-low segment pattern, bit order {g,f,e,d,c,b,a}.
REQ-006 dig_sel  in  4  active-high digit strobe; bit n selects digit n.
REQ-007 frame_start  in  1  single-cycle pulse that begins a 4-digit capture.
REQ-008 out_ready  in  1  downstream accepts the result.
REQ-009 out_valid  out  1  result frame available.
REQ-010 value  out  16  captured digits; digit n in value[4n+3:4n].
REQ-011 err  out  1  at least one digit in the held frame failed to decode; valid only while out_valid is high.
REQ-012 timeout  out  1  single-cycle pulse when a frame is abandoned.

Function
REQ-013 The decode table SHALL be: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 1111111->F (blank); any other pattern->E and marks the frame as erroneous.
REQ-014 The FSM SHALL have states IDLE, CAPTURE and HOLD.
REQ-015 IDLE: frame_start=1 -> CAPTURE next cycle; captured-mask, error flag, timeout counter and stability counter SHALL be cleared.
REQ-016 CAPTURE: the stability counter SHALL increment each cycle dig_sel is one-hot and equal to its previous-cycle value, saturating at SETTLE; any other dig_sel value (zero, multi-hot or changed) SHALL reset it to 0.
REQ-017 CAPTURE: on the cycle the counter first reaches SETTLE, if the mask bit for the selected digit is 0, the decoded seg_in SHALL be written to that digit slot and the mask bit set; digits already captured SHALL NOT be overwritten.
REQ-018 The cycle the mask becomes 4'b1111 -> HOLD next cycle with out_valid=1.
REQ-019 HOLD: value and err SHALL stay constant; out_valid SHALL remain 1 until a cycle with out_valid=1 and out_ready=1, after which out_valid=0 and the state is IDLE.
REQ-020 The timeout counter SHALL increment every CAPTURE cycle; on reaching TIMEOUT with the mask incomplete -> IDLE, timeout pulses 1 for one cycle, and value is unchanged from its prior contents.
REQ-021 frame_start in CAPTURE SHALL restart the capture exactly as in REQ-015, with no timeout pulse; frame_start in HOLD SHALL be ignored.
REQ-022 Completion and timeout occurring in the same cycle: completion SHALL win and no timeout pulse is generated.
REQ-023 Latency: with an ideal scan, out_valid SHALL rise no earlier than SETTLE+1 cycles after the fourth digit's strobe first becomes stable.

Reset
REQ-024 RESET=1 SHALL force IDLE, out_valid=0, err=0, timeout=0, value=16'hFFFF, and clear the mask and all counters; this SHALL take effect in any state, including mid-CAPTURE and during HOLD.
REQ-025 On the first cycle after RESET deasserts, the block SHALL accept frame_start.

Verification
REQ-026 SETTLE=4, frame_start, then strobes 0001..1000 each for 6 cycles with patterns for 3,0,2,1 -> out_valid=1, value=16'h1203, err=0.
REQ-027 Same as REQ-026 with digit 2 pattern 1010101 -> value=16'h1E03, err=1.
REQ-028 Hold out_ready=0 for 10 cycles after out_valid; pulse frame_start during HOLD -> value stable, out_valid stays 1; out_ready=1 -> out_valid=0 next cycle.
REQ-029 Strobe each digit for only 3 cycles (SETTLE=4), TIMEOUT=64 -> no capture; timeout=1 for one cycle at CAPTURE cycle 64; state IDLE.
REQ-030 Multi-hot dig_sel=0011 for 10 cycles, then a valid scan -> the first two digits are not captured during the multi-hot period; the frame completes normally afterward.
REQ-031 RESET asserted after two digits are captured -> out_valid=0 and value=16'hFFFF; a new frame then completes correctly.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// Recovers a 4-digit value from a multiplexed, active-low 7-segment display scan.
// Each digit is sampled once its strobe has been stable and one-hot for SETTLE cycles.
module seg7_scan_reader #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_sel,
    input  logic        frame_start,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] value,
    output logic        err,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

    localparam logic [7:0]  SETTLE_C  = 8'(SETTLE);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    // Returns {bad, nibble}; unknown patterns decode to E and flag the frame.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'b1000000: return {1'b0, 4'h0};
            7'b1111001: return {1'b0, 4'h1};
            7'b0100100: return {1'b0, 4'h2};
            7'b0110000: return {1'b0, 4'h3};
            7'b0011001: return {1'b0, 4'h4};
            7'b0010010: return {1'b0, 4'h5};
            7'b0000010: return {1'b0, 4'h6};
            7'b1111000: return {1'b0, 4'h7};
            7'b0000000: return {1'b0, 4'h8};
            7'b0010000: return {1'b0, 4'h9};
            7'b1111111: return {1'b0, 4'hF};
            default:    return {1'b1, 4'hE};
        endcase
    endfunction

    function automatic logic [1:0] sel_index(input logic [3:0] sel);
        case (sel)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic        err_acc_q, err_acc_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [7:0]  scnt_q, scnt_d;
    logic [3:0]  prev_sel_q, prev_sel_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] value_q, value_d;
    logic        err_q, err_d;
    logic        timeout_q, timeout_d;

    logic        sel_stable;
    logic [7:0]  scnt_inc;
    logic [15:0] tcnt_inc;
    logic [4:0]  dec;
    logic [1:0]  idx;
    logic        cap_new;
    logic [3:0]  mask_upd;
    logic        in_capture;
    logic        frame_done;
    logic        frame_expired;

    // Shared capture-path decisions used by both the FSM and the datapath.
    always_comb begin
        in_capture    = (state_q == CAPTURE) && !frame_start;
        sel_stable    = $onehot(dig_sel) && (dig_sel == prev_sel_q);
        scnt_inc      = (scnt_q == SETTLE_C) ? scnt_q : scnt_q + 8'd1;
        tcnt_inc      = tcnt_q + 16'd1;
        dec           = decode_seg(seg_in);
        idx           = sel_index(dig_sel);
        cap_new       = in_capture && sel_stable && (scnt_q != SETTLE_C)
                        && (scnt_inc == SETTLE_C) && !mask_q[idx];
        mask_upd      = mask_q | (cap_new ? (4'b0001 << idx) : 4'b0000);
        frame_done    = in_capture && (mask_upd == 4'b1111);
        frame_expired = in_capture && !frame_done && (tcnt_inc == TIMEOUT_C);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (frame_start) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (frame_start)        state_d = CAPTURE;
                else if (frame_done)    state_d = HOLD;
                else if (frame_expired) state_d = IDLE;
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == HOLD);
        value     = value_q;
        err       = err_q;
        timeout   = timeout_q;
    end

    always_comb begin
        mask_d     = mask_q;
        err_acc_d  = err_acc_q;
        tcnt_d     = tcnt_q;
        scnt_d     = scnt_q;
        prev_sel_d = dig_sel;
        buf_d      = buf_q;
        value_d    = value_q;
        err_d      = err_q;
        timeout_d  = 1'b0;

        if (frame_start && state_q != HOLD) begin
            mask_d    = 4'b0000;
            err_acc_d = 1'b0;
            tcnt_d    = 16'd0;
            scnt_d    = 8'd0;
        end else if (state_q == CAPTURE) begin
            scnt_d = sel_stable ? scnt_inc : 8'd0;
            tcnt_d = tcnt_inc;
            mask_d = mask_upd;
            if (cap_new) begin
                buf_d[{idx, 2'b00} +: 4] = dec[3:0];
                err_acc_d                = err_acc_q | dec[4];
            end
            // The result register only changes on a completed frame.
            if (frame_done) begin
                value_d = buf_d;
                err_d   = err_acc_d;
            end
            timeout_d = frame_expired;
        end else if (state_q == HOLD && out_ready) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            mask_q     <= 4'b0000;
            err_acc_q  <= 1'b0;
            tcnt_q     <= 16'd0;
            scnt_q     <= 8'd0;
            prev_sel_q <= 4'b0000;
            value_q    <= 16'hFFFF;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            err_acc_q  <= err_acc_d;
            tcnt_q     <= tcnt_d;
            scnt_q     <= scnt_d;
            prev_sel_q <= prev_sel_d;
            value_q    <= value_d;
            err_q      <= err_d;
            timeout_q  <= timeout_d;
        end
    end

    // Digit slots are gated by the mask, so the staging buffer needs no reset.
    always_ff @(posedge CLOCK_50) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader with SETTLE=4, TIMEOUT=64.
module tb_seg7_scan_reader;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] SBL  = 7'b1111111;
    localparam logic [6:0] SBAD = 7'b1010101;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic [6:0]  seg_in = 7'b1111111;
    logic [3:0]  dig_sel = 4'b0000;
    logic        frame_start = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] value;
    logic        err;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int to_cnt  = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    seg7_scan_reader #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .seg_in     (seg_in),
        .dig_sel    (dig_sel),
        .frame_start(frame_start),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .value      (value),
        .err        (err),
        .timeout    (timeout)
    );

    always @(negedge CLOCK_50) if (timeout === 1'b1) to_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic sample();
        @(negedge CLOCK_50);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        dig_sel     = 4'b0000;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                        input logic [6:0] p3, input int n, input int ndig);
        logic [6:0] pats [4];
        pats = '{p0, p1, p2, p3};
        for (int d = 0; d < ndig; d++) begin
            dig_sel = 4'b0001 << d;
            seg_in  = pats[d];
            repeat (n) tick();
        end
        dig_sel = 4'b0000;
        seg_in  = 7'b1111111;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        sample();
        chk(tag, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int first_to;
        int to0;
        logic vseen;

        // Power-on reset
        RESET = 1'b1;
        repeat (3) tick();
        sample();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_value", 32'(value), 32'h0000FFFF);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        tick();
        RESET = 1'b0;

        // Basic frame 3,0,2,1
        start_frame();
        scan(S3, S0, S2, S1, 6, 4);
        sample();
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_value", 32'(value), 32'h1203);
        chk("basic_err", 32'(err), 32'd0);
        handshake("basic_ack");

        // Undecodable digit 2, then hold with frame_start ignored
        start_frame();
        scan(S3, S0, SBAD, S1, 6, 4);
        sample();
        chk("bad_valid", 32'(out_valid), 32'd1);
        chk("bad_value", 32'(value), 32'h1E03);
        chk("bad_err", 32'(err), 32'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            frame_start = (i == 4);
            tick();
        end
        frame_start = 1'b0;
        sample();
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_value", 32'(value), 32'h1E03);
        chk("hold_err", 32'(err), 32'd1);
        handshake("hold_ack");

        // Minimum strobe length that still captures (SETTLE+1 cycles)
        start_frame();
        scan(S5, S4, SBL, S6, 5, 4);
        sample();
        chk("min_valid", 32'(out_valid), 32'd1);
        chk("min_value", 32'(value), 32'h6F45);
        chk("min_err", 32'(err), 32'd0);
        handshake("min_ack");

        // Strobes one cycle too short, partial capture, then restart mid-capture
        start_frame();
        scan(S8, S8, S8, S8, 4, 4);
        sample();
        chk("short_no_valid", 32'(out_valid), 32'd0);
        tick();
        scan(S9, S9, S9, S9, 6, 2);
        to0 = to_cnt;
        start_frame();
        scan(S3, S0, S2, S1, 6, 4);
        sample();
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_value", 32'(value), 32'h1203);
        chk("restart_no_to", 32'(to_cnt - to0), 32'd0);
        handshake("restart_ack");

        // Timeout: 3-cycle strobes never settle
        to0      = to_cnt;
        first_to = 0;
        vseen    = 1'b0;
        start_frame();
        for (int c = 1; c <= 70; c++) begin
            dig_sel = 4'b0001 << (((c - 1) / 3) % 4);
            seg_in  = S8;
            sample();
            if (timeout === 1'b1 && first_to == 0) first_to = c;
            if (out_valid !== 1'b0) vseen = 1'b1;
            tick();
        end
        dig_sel = 4'b0000;
        sample();
        chk("to_cycle", 32'(first_to), 32'd65);
        chk("to_pulses", 32'(to_cnt - to0), 32'd1);
        chk("to_no_valid", 32'(vseen), 32'd0);
        chk("to_value_kept", 32'(value), 32'h1203);
        tick();

        // Multi-hot strobe must not capture, then a clean scan completes
        start_frame();
        dig_sel = 4'b0011;
        seg_in  = S9;
        repeat (10) tick();
        sample();
        chk("multi_no_valid", 32'(out_valid), 32'd0);
        tick();
        scan(S7, S6, S5, S4, 6, 4);
        sample();
        chk("multi_valid", 32'(out_valid), 32'd1);
        chk("multi_value", 32'(value), 32'h4567);
        handshake("multi_ack");

        // Reset mid-capture, then a frame started right after reset
        start_frame();
        scan(S1, S2, S1, S2, 6, 2);
        RESET = 1'b1;
        tick();
        sample();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_value", 32'(value), 32'h0000FFFF);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_timeout", 32'(timeout), 32'd0);
        tick();
        RESET = 1'b0;
        start_frame();
        scan(S9, S8, S7, S6, 6, 4);
        sample();
        chk("post_valid", 32'(out_valid), 32'd1);
        chk("post_value", 32'(value), 32'h6789);
        chk("post_err", 32'(err), 32'd0);

        // Reset while holding a result
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        sample();
        chk("holdrst_valid", 32'(out_valid), 32'd0);
        chk("holdrst_value", 32'(value), 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
